rsa_exp_seq: RTL and testbench

Square-and-multiply sequencer for the RSA peripheral. It scans an exponent MSB-first and issues one modular-multiply operation at a time. For each operation it drives the operand-select codes of the two operand muxes in front of the multiplier. It then waits for the multiplier to finish and strobes the accumulator write-enable. It sits between the register interface (start/exponent) and the multiplier datapath, and is the control end of the operand-select interface.

---
 rtl/rsa_exp_seq.sv | 165 ++++++++++++++++
 tb/tb_rsa_exp_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_seq.sv
// Square-and-multiply sequencer: scans the exponent MSB-first and issues one modular multiply at a time.
// Define RSA_EXP_SEQ_LZ_SKIP_EN to skip leading zero bits; otherwise a fixed ONE + SQR/MUL-per-bit sequence runs.
module rsa_exp_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] exponent,
  input  logic             mult_done,
  output logic             mult_start,
  output logic [1:0]       op_a_sel,
  output logic [1:0]       op_b_sel,
  output logic             acc_we,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] SEL_ONE  = 2'b00;
  localparam logic [1:0] SEL_ACC  = 2'b01;
  localparam logic [1:0] SEL_BASE = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             one_q, one_d;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [IW-1:0]    idx_m1;

  assign idx_m1   = idx_q - IW'(1);
  assign op_a_sel = sel_a_q;
  assign op_b_sel = sel_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      one_q   <= 1'b0;
      sel_a_q <= SEL_ZERO;
      sel_b_q <= SEL_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      one_q   <= one_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  // Captured exponent is pure data; it only matters once a start has loaded it.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    one_d      = one_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    mult_start = 1'b0;
    acc_we     = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = exponent;
          idx_d   = IW'(WIDTH - 1);
          pend_d  = 1'b0;
          one_d   = 1'b0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
`ifdef RSA_EXP_SEQ_LZ_SKIP_EN
        if (exp_q[idx_q]) begin
          sel_a_d = SEL_BASE;
          sel_b_d = SEL_ONE;
          one_d   = 1'b0;
          state_d = S_ISSUE;
        end else if (idx_q == '0) begin
          sel_a_d = SEL_ONE;
          sel_b_d = SEL_ONE;
          one_d   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          idx_d = idx_m1;
        end
`else
        sel_a_d = SEL_ONE;
        sel_b_d = SEL_ONE;
        one_d   = 1'b1;
        state_d = S_ISSUE;
`endif
      end

      S_ISSUE: begin
        mult_start = 1'b1;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (mult_done) begin
          acc_we = 1'b1;
          if (pend_q) begin
            pend_d  = 1'b0;
            one_d   = 1'b0;
            sel_a_d = SEL_ACC;
            sel_b_d = SEL_BASE;
            state_d = S_ISSUE;
`ifdef RSA_EXP_SEQ_LZ_SKIP_EN
          end else if ((idx_q == '0) || one_q) begin
            sel_a_d = SEL_ZERO;
            sel_b_d = SEL_ZERO;
            state_d = S_DONE;
`else
          end else if (one_q) begin
            // After ONE the first square consumes the MSB without moving idx.
            one_d   = 1'b0;
            sel_a_d = SEL_ACC;
            sel_b_d = SEL_ACC;
            pend_d  = exp_q[idx_q];
            state_d = S_ISSUE;
          end else if (idx_q == '0) begin
            sel_a_d = SEL_ZERO;
            sel_b_d = SEL_ZERO;
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_m1;
            one_d   = 1'b0;
            sel_a_d = SEL_ACC;
            sel_b_d = SEL_ACC;
            pend_d  = exp_q[idx_m1];
            state_d = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_exp_seq.sv
// Scoreboard bench for rsa_exp_seq (WIDTH=4): expected operand-select pairs are queued at start
// and popped on each mult_start; a cycle-accurate multiplier stub with latency L drives mult_done.
module tb_rsa_exp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] exponent;
  logic       mult_done;
  logic       mult_start;
  logic [1:0] op_a_sel;
  logic [1:0] op_b_sel;
  logic       acc_we;
  logic       busy;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  rsa_exp_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .exponent(exponent), .mult_done(mult_done),
    .mult_start(mult_start), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel),
    .acc_we(acc_we), .busy(busy), .done(done)
  );

  // Reference op list built straight from the square-and-multiply algorithm.
  task automatic build_expected(input logic [3:0] e, output int scan);
    int top;
    q.delete();
`ifdef RSA_EXP_SEQ_LZ_SKIP_EN
    top = -1;
    for (int i = 3; i >= 0; i--) if (e[i] && top < 0) top = i;
    if (top < 0) begin
      q.push_back(4'b0000);
      scan = 4;
    end else begin
      q.push_back(4'b1000);
      for (int i = top - 1; i >= 0; i--) begin
        q.push_back(4'b0101);
        if (e[i]) q.push_back(4'b0110);
      end
      scan = 4 - top;
    end
`else
    q.push_back(4'b0000);
    for (int i = 3; i >= 0; i--) begin
      q.push_back(4'b0101);
      if (e[i]) q.push_back(4'b0110);
    end
    scan = 1;
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({mult_start, acc_we, busy, done, op_a_sel, op_b_sel} !== 8'b0000_1111) begin
      n_fail++;
      $display("FAIL %s: ms/we/busy/done/a/b got %b required 00001111", tag,
               {mult_start, acc_we, busy, done, op_a_sel, op_b_sel});
    end
  endtask

  task automatic run_seq(input logic [3:0] e, input int lat, input bit stray,
                         input bit repulse, input int abort_op);
    int scan, cyc, wleft, ops, total, ms_cnt, aw_cnt;
    bit exp_dn, next_issue, fin, in_wait, aw_exp, exp_ms, aborted;
    logic [3:0] cur;
    build_expected(e, scan);
    total = q.size();
    exponent = e;
    start = 1'b1;
    cyc = 0; wleft = 0; ops = 0; ms_cnt = 0; aw_cnt = 0;
    exp_dn = 0; next_issue = 0; fin = 0; aborted = 0; cur = 4'b1111;
    while (!fin && !aborted && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = repulse && (cyc == 3 || cyc == 6);
      exponent = ~e;
      in_wait = (wleft > 0);
      aw_exp = 0;
      mult_done = 1'b0;
      if (wleft > 0) begin
        wleft--;
        if (wleft == 0) begin
          mult_done = 1'b1;
          aw_exp = 1;
        end
      end else if (stray && (cyc == 1 || next_issue)) begin
        mult_done = 1'b1;
      end
      if (abort_op > 0 && ops == abort_op && in_wait && !aw_exp) begin
        rst = 1'b1;
        mult_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check_idle_outputs("reset_in_wait");
        mult_done = 1'b1;
        #1;
        n_cmp++;
        if (acc_we !== 1'b0) begin
          n_fail++;
          $display("FAIL late_done_we: acc_we got %b required 0", acc_we);
        end
        @(negedge clk);
        mult_done = 1'b0;
        q.delete();
        aborted = 1;
      end else begin
        #1;
        exp_ms = (cyc == scan + 1) || next_issue;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy e=%b cyc=%0d: got %b required 1", e, cyc, busy);
        end
        n_cmp++;
        if (done !== exp_dn) begin
          n_fail++;
          $display("FAIL done e=%b cyc=%0d: got %b required %b", e, cyc, done, exp_dn);
        end
        n_cmp++;
        if (acc_we !== aw_exp) begin
          n_fail++;
          $display("FAIL acc_we e=%b cyc=%0d: got %b required %b", e, cyc, acc_we, aw_exp);
        end
        if (in_wait) begin
          n_cmp++;
          if ({op_a_sel, op_b_sel} !== cur) begin
            n_fail++;
            $display("FAIL sel_hold e=%b cyc=%0d: got %b required %b", e, cyc,
                     {op_a_sel, op_b_sel}, cur);
          end
        end
        n_cmp++;
        if (mult_start !== exp_ms) begin
          n_fail++;
          $display("FAIL mult_start e=%b cyc=%0d: got %b required %b", e, cyc, mult_start, exp_ms);
        end
        ms_cnt += (mult_start === 1'b1) ? 1 : 0;
        aw_cnt += (acc_we === 1'b1) ? 1 : 0;
        if (exp_ms) begin
          if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL op_queue e=%b cyc=%0d: got extra op required none", e, cyc);
          end else begin
            cur = q.pop_front();
            n_cmp++;
            if ({op_a_sel, op_b_sel} !== cur) begin
              n_fail++;
              $display("FAIL op_sel e=%b op=%0d: got %b required %b", e, ops,
                       {op_a_sel, op_b_sel}, cur);
            end
          end
          wleft = lat;
          ops++;
        end
        if (exp_dn) fin = 1;
        next_issue = aw_exp && (q.size() != 0);
        exp_dn = aw_exp && (q.size() == 0);
      end
    end
    mult_done = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      if (!fin) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout e=%b: done not seen in %0d cycles", e, cyc);
      end
      n_cmp++;
      if (ms_cnt != total || aw_cnt != total) begin
        n_fail++;
        $display("FAIL op_count e=%b: got %0d starts %0d writes required %0d", e, ms_cnt, aw_cnt, total);
      end
      @(negedge clk);
      #1 check_idle_outputs("idle_after_done");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; exponent = 4'b0; mult_done = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset_values");
    rst = 1'b0;
    mult_done = 1'b1;
    @(negedge clk);
    #1 check_idle_outputs("idle_ignores_mult_done");
    mult_done = 1'b0;
  endtask

  task automatic test_patterns;
    run_seq(4'b1011, 1, 0, 0, 0);
    run_seq(4'b0000, 1, 0, 0, 0);
    run_seq(4'b1111, 2, 0, 0, 0);
    run_seq(4'b0001, 3, 0, 0, 0);
    run_seq(4'b0100, 1, 0, 0, 0);
  endtask

  task automatic test_stray_done;
    run_seq(4'b1011, 5, 1, 0, 0);
    run_seq(4'b0010, 5, 1, 0, 0);
  endtask

  task automatic test_start_while_busy;
    run_seq(4'b1011, 2, 0, 1, 0);
  endtask

  task automatic test_reset_mid;
    run_seq(4'b1011, 3, 0, 0, 2);
    run_seq(4'b1011, 1, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    run_seq(4'b0110, 1, 0, 0, 0);
    run_seq(4'b1001, 2, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stray_done();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
